// File: rtl/alu_pkg.sv
// Shared ALU execute-path types: divider opcodes, divider issue FSM states and datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/complete sequencer in front of the iterative RV32M divider.
// Define DIV_REUSE_EN to keep the last completed division and answer a repeat of it without relaunching.
module div_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o,
  output logic            div_start_o,
  output logic            div_sign_o,
  output logic            div_stall_o,
  output logic            div_flush_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i,
  input  logic            div_valid_i
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid & ready are both high
  // and neither stall_i nor flush_i is asserted; ready/valid themselves only reflect FSM state.

  div_state_e      state, state_d;
  div_op_e         op;
  logic            accept, capture, hit;
  logic            op_sign, op_rem;
  logic            sign_q, rem_q, flush_q;
  logic [XLEN-1:0] dividend_q, divisor_q, result_q, hit_result;
  logic [RD_W-1:0] rd_q;

  assign op      = div_op_e'(op_i);
  assign op_sign = (op == OP_DIV) || (op == OP_REM);
  assign op_rem  = (op == OP_REM) || (op == OP_REMU);

`ifdef DIV_REUSE_EN
  logic            reuse_valid, c_sign;
  logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem;

  // A DIV/REM pair on the same operands shares one divider run.
  assign hit        = reuse_valid && (rs1_i == c_rs1) && (rs2_i == c_rs2) && (op_sign == c_sign);
  assign hit_result = op_rem ? c_rem : c_quo;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      reuse_valid <= 1'b0;
      c_sign      <= 1'b0;
      c_rs1       <= '0;
      c_rs2       <= '0;
      c_quo       <= '0;
      c_rem       <= '0;
    end else if (flush_i) begin
      reuse_valid <= 1'b0;
    end else if (capture) begin
      reuse_valid <= 1'b1;
      c_sign      <= sign_q;
      c_rs1       <= dividend_q;
      c_rs2       <= divisor_q;
      c_quo       <= div_quotient_i;
      c_rem       <= div_remainder_i;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (in_valid_i) begin
        accept  = 1'b1;
        state_d = hit ? DONE : ARM;
      end
      // div_valid_i is still high from the divider's idle state; wait for it to drop.
      ARM:  if (!div_valid_i) state_d = BUSY;
      BUSY: if (div_valid_i) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stall_i || flush_i) begin
      accept  = 1'b0;
      capture = 1'b0;
      state_d = flush_i ? IDLE : state;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state      <= IDLE;
      flush_q    <= 1'b0;
      sign_q     <= 1'b0;
      rem_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      state   <= state_d;
      flush_q <= flush_i;
      if (accept) begin
        dividend_q <= rs1_i;
        divisor_q  <= rs2_i;
        sign_q     <= op_sign;
        rem_q      <= op_rem;
        rd_q       <= rd_i;
        if (hit) result_q <= hit_result;
      end
      if (capture) result_q <= rem_q ? div_remainder_i : div_quotient_i;
    end
  end

  assign in_ready_o     = (state == IDLE);
  assign out_valid_o    = (state == DONE);
  assign div_start_o    = (state == ARM) || (state == BUSY);
  assign div_sign_o     = sign_q;
  assign div_stall_o    = stall_i;
  assign div_flush_o    = flush_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign result_o       = result_q;
  assign rd_o           = rd_q;

endmodule
